detect_window_counter: RTL

Downstream consumer of the run-of-ones Mealy detector's `detect` output. Over a programmable window of clock cycles it measures three things: how many separate detect runs occur, how many cycles `detect` is high, and how long the longest continuous high stretch is. At the end of the window it publishes the results with a one-cycle `report_valid` strobe. It sits between the detector and the status/readout logic.

---
 rtl/detect_window_counter_if.sv | 25 ++
 rtl/detect_window_counter.sv | 101 ++++++++++
 2 files changed

// File: rtl/detect_window_counter_if.sv
// Handshake and result bundle between a window-counter requester and the counter.
interface detect_window_counter_if #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned WIN_W = 16
);
    logic             start;
    logic [WIN_W-1:0] win_len;
    logic             detect;
    logic             busy;
    logic             report_valid;
    logic [CNT_W-1:0] run_count;
    logic [CNT_W-1:0] hit_count;
    logic [CNT_W-1:0] longest_run;
    logic             overflow;

    modport master (
        output start, win_len, detect,
        input  busy, report_valid, run_count, hit_count, longest_run, overflow
    );

    modport slave (
        input  start, win_len, detect,
        output busy, report_valid, run_count, hit_count, longest_run, overflow
    );
endinterface

// File: rtl/detect_window_counter.sv
// Measures detect runs, high cycles and longest high stretch over a programmable
// window, publishing saturating results with a one-cycle report strobe.
module detect_window_counter #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned WIN_W = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    detect_window_counter_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COUNT  = 2'd1,
        REPORT = 2'd2
    } state_e;

    state_e           state_q;
    logic [WIN_W-1:0] rem_q;
    logic [CNT_W-1:0] hit_acc_q, run_acc_q, cur_run_q, long_acc_q;
    logic             prev_det_q, ovf_acc_q;
    logic [CNT_W-1:0] hit_cnt_q, run_cnt_q, long_run_q;
    logic             overflow_q;

    logic [CNT_W-1:0] hit_acc_d, run_acc_d, cur_run_d, long_acc_d;
    logic             rise_c, sat_c;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    // Per-sample accumulator update, including this cycle's detect.
    always_comb begin
        rise_c     = bus.detect & ~prev_det_q;
        hit_acc_d  = bus.detect ? sat_inc(hit_acc_q) : hit_acc_q;
        run_acc_d  = rise_c ? sat_inc(run_acc_q) : run_acc_q;
        cur_run_d  = bus.detect ? sat_inc(cur_run_q) : '0;
        long_acc_d = (cur_run_d > long_acc_q) ? cur_run_d : long_acc_q;
        sat_c      = (bus.detect && ((hit_acc_q == CNT_MAX) || (cur_run_q == CNT_MAX)))
                   || (rise_c && (run_acc_q == CNT_MAX));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            rem_q      <= '0;
            hit_acc_q  <= '0;
            run_acc_q  <= '0;
            cur_run_q  <= '0;
            long_acc_q <= '0;
            prev_det_q <= 1'b0;
            ovf_acc_q  <= 1'b0;
            hit_cnt_q  <= '0;
            run_cnt_q  <= '0;
            long_run_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start && (bus.win_len != '0)) begin
                        rem_q      <= bus.win_len;
                        hit_acc_q  <= '0;
                        run_acc_q  <= '0;
                        cur_run_q  <= '0;
                        long_acc_q <= '0;
                        prev_det_q <= 1'b0;
                        ovf_acc_q  <= 1'b0;
                        state_q    <= COUNT;
                    end
                end
                COUNT: begin
                    hit_acc_q  <= hit_acc_d;
                    run_acc_q  <= run_acc_d;
                    cur_run_q  <= cur_run_d;
                    long_acc_q <= long_acc_d;
                    prev_det_q <= bus.detect;
                    ovf_acc_q  <= ovf_acc_q | sat_c;
                    rem_q      <= rem_q - WIN_W'(1);
                    // Last sample of the window: publish including this sample.
                    if (rem_q == WIN_W'(1)) begin
                        hit_cnt_q  <= hit_acc_d;
                        run_cnt_q  <= run_acc_d;
                        long_run_q <= long_acc_d;
                        overflow_q <= ovf_acc_q | sat_c;
                        state_q    <= REPORT;
                    end
                end
                REPORT:  state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy         = (state_q == COUNT) || (state_q == REPORT);
    assign bus.report_valid = (state_q == REPORT);
    assign bus.run_count    = run_cnt_q;
    assign bus.hit_count    = hit_cnt_q;
    assign bus.longest_run  = long_run_q;
    assign bus.overflow     = overflow_q;
endmodule
